// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the parametrised true dual-port RAM.
//   ST_IDLE / ST_CLEAR       : clear-engine state encoding
//   COLL_A_WINS/B_WINS/NONE  : write-write same-address resolution policies
//   be_merge()               : overlays the enabled bytes of a new word onto an old word
package tdp_ram_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam int COLL_A_WINS = 0;
   localparam int COLL_B_WINS = 1;
   localparam int COLL_NONE   = 2;

   // The merge works on the widest supported word; callers widen their operands
   // into it and narrow the result back to their own data width.
   localparam int MAX_DW = 256;

   typedef logic [MAX_DW-1:0]   word_t;
   typedef logic [MAX_DW/8-1:0] be_t;

   function automatic word_t be_merge(input word_t old_w, input word_t new_w, input be_t be);
      word_t res;
      res = old_w;
      for (int i = 0; i < MAX_DW/8; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tdp_ram_param_if.sv
// One RAM access port (request, write data, read data and read-valid).
//   En    : request valid          We   : 1 = write, 0 = read
//   Be    : byte enables (writes)  Addr : word address
//   Din   : write data             Dout : read data (held between reads)
//   Vld   : one-cycle read-data valid pulse
// master = datapath side driving requests, slave = RAM side.
interface tdp_ram_param_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic            En;
   logic            We;
   logic [DW/8-1:0] Be;
   logic [AW-1:0]   Addr;
   logic [DW-1:0]   Din;
   logic [DW-1:0]   Dout;
   logic            Vld;

   modport master (output En, We, Be, Addr, Din, input  Dout, Vld);
   modport slave  (input  En, We, Be, Addr, Din, output Dout, Vld);
endinterface

// File: rtl/tdp_ram_rdpipe.sv
// Per-port read-data / valid pipeline.
//   Clk, Clr : clock, asynchronous active-high reset (flushes valids, zeroes data)
//   vld_p0   : a read was accepted this cycle
//   data_p0  : word read from the array this cycle (0 for out-of-range addresses)
//   dout,vld : port read data and valid pulse, latency 1 (OUT_REG=0) or 2 (OUT_REG=1)
// Data registers only load alongside a valid so dout holds its last read value.
module tdp_ram_rdpipe
   import tdp_ram_pkg::*;
#(
   parameter int DW      = 8,
   parameter int OUT_REG = 0
)(
   input  logic          Clk,
   input  logic          Clr,
   input  logic          vld_p0,
   input  logic [DW-1:0] data_p0,
   output logic [DW-1:0] dout,
   output logic          vld
);

   logic [DW-1:0] data_p1;
   logic          vld_p1;

   // p0 -> p1 : array read register
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) data_p1 <= data_p0;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] data_p2;
      logic          vld_p2;

      // p1 -> p2 : optional output register
      always_ff @(posedge Clk or posedge Clr) begin
         if (Clr) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
         end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) data_p2 <= data_p1;
         end
      end

      assign dout = data_p2;
      assign vld  = vld_p2;
   end else begin : g_no_out_reg
      assign dout = data_p1;
      assign vld  = vld_p1;
   end

endmodule

// File: rtl/tdp_ram_param.sv
// Parametrised true dual-port synchronous RAM with byte enables, optional output
// register, write-write collision policy and a sequenced clear engine.
//   Clk, Clr       : clock, asynchronous active-high reset (starts a full clear)
//   Init           : pulse in IDLE starts a sequenced clear of all DEPTH words
//   SPM            : single-port mode, port B requests are ignored
//   Busy           : clear engine running; all requests are dropped meanwhile
//   port_a, port_b : access ports (see tdp_ram_param_if)
//   Coll           : sticky, same-address write-write collision seen
//   OobErr         : sticky, access with address >= DEPTH seen
// Cross-port read during write returns the old word (read-first).
module tdp_ram_param
   import tdp_ram_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int DEPTH     = 2**AW,
   parameter int OUT_REG   = 0,
   parameter int COLL_MODE = COLL_A_WINS
)(
   input  logic           Clk,
   input  logic           Clr,
   input  logic           Init,
   input  logic           SPM,
   output logic           Busy,
   tdp_ram_param_if.slave port_a,
   tdp_ram_param_if.slave port_b,
   output logic           Coll,
   output logic           OobErr
);

   logic [0:0]    state;
   logic [AW-1:0] cnt;
   logic [DW-1:0] mem [DEPTH];

   logic          req_a, req_b;
   logic          oob_a, oob_b;
   logic          wreq_a, wreq_b;
   logic          hit;
   logic          commit_a, commit_b;
   logic          vld_a_p0, vld_b_p0;
   logic [DW-1:0] data_a_p0, data_b_p0;

   assign Busy = (state == ST_CLEAR);

   // Requests only exist outside the clear; SPM makes port B look idle.
   assign req_a = port_a.En & ~Busy;
   assign req_b = port_b.En & ~Busy & ~SPM;

   assign oob_a = ({1'b0, port_a.Addr} >= (AW+1)'(DEPTH));
   assign oob_b = ({1'b0, port_b.Addr} >= (AW+1)'(DEPTH));

   assign wreq_a = req_a & port_a.We;
   assign wreq_b = req_b & port_b.We;

   // A collision is flagged on matching addresses even if the enables are zero
   // or the address is out of range; the policy only decides who commits.
   assign hit = wreq_a & wreq_b & (port_a.Addr == port_b.Addr);

   assign commit_a = wreq_a & ~oob_a & (~hit | (COLL_MODE == COLL_A_WINS));
   assign commit_b = wreq_b & ~oob_b & (~hit | (COLL_MODE == COLL_B_WINS));

   // Clear engine: one word per edge, counter restarts on every entry.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Init) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
               end
            end
            default: begin
               if (cnt == AW'(DEPTH-1)) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
         endcase
      end
   end

   // Storage has no reset; the clear engine is the only way to zero it.
   always_ff @(posedge Clk) begin
      if (Busy) begin
         mem[cnt] <= '0;
      end else begin
         if (commit_a)
            mem[port_a.Addr] <= DW'(be_merge(word_t'(mem[port_a.Addr]),
                                             word_t'(port_a.Din), be_t'(port_a.Be)));
         if (commit_b)
            mem[port_b.Addr] <= DW'(be_merge(word_t'(mem[port_b.Addr]),
                                             word_t'(port_b.Din), be_t'(port_b.Be)));
      end
   end

   // Sticky flags; entering the clear wins over a same-cycle event.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         Coll   <= 1'b0;
         OobErr <= 1'b0;
      end else if ((state == ST_IDLE) && Init) begin
         Coll   <= 1'b0;
         OobErr <= 1'b0;
      end else begin
         if (hit) Coll <= 1'b1;
         if ((req_a & oob_a) | (req_b & oob_b)) OobErr <= 1'b1;
      end
   end

   // p0 : array read (old contents, before this edge's writes)
   assign vld_a_p0  = req_a & ~port_a.We;
   assign vld_b_p0  = req_b & ~port_b.We;
   assign data_a_p0 = oob_a ? '0 : mem[port_a.Addr];
   assign data_b_p0 = oob_b ? '0 : mem[port_b.Addr];

   tdp_ram_rdpipe #(.DW(DW), .OUT_REG(OUT_REG)) u_rdpipe_a (
      .Clk     (Clk),
      .Clr     (Clr),
      .vld_p0  (vld_a_p0),
      .data_p0 (data_a_p0),
      .dout    (port_a.Dout),
      .vld     (port_a.Vld)
   );

   tdp_ram_rdpipe #(.DW(DW), .OUT_REG(OUT_REG)) u_rdpipe_b (
      .Clk     (Clk),
      .Clr     (Clr),
      .vld_p0  (vld_b_p0),
      .data_p0 (data_b_p0),
      .dout    (port_b.Dout),
      .vld     (port_b.Vld)
   );

endmodule

// File: tb/tb_tdp_ram_param.sv
// Bench for tdp_ram_param: three instances (DW=16, AW=8) share one stimulus stream.
//   dut0 : DEPTH=200, OUT_REG=0, A wins
//   dut1 : DEPTH=200, OUT_REG=1, B wins
//   dut2 : DEPTH=256, OUT_REG=1, neither writes
// A word-level reference model with a due-time read scoreboard predicts every output.
module tb_tdp_ram_param;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, init, spm;
   logic        en_a, we_a, en_b, we_b;
   logic [1:0]  be_a, be_b;
   logic [7:0]  addr_a, addr_b;
   logic [15:0] din_a, din_b;

   logic        busy_o  [NDUT];
   logic        coll_o  [NDUT];
   logic        oob_o   [NDUT];
   logic        vld_a_o [NDUT];
   logic        vld_b_o [NDUT];
   logic [15:0] dout_a_o[NDUT];
   logic [15:0] dout_b_o[NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      tdp_ram_param_if #(.DW(16), .AW(8)) pa ();
      tdp_ram_param_if #(.DW(16), .AW(8)) pb ();

      assign pa.En   = en_a;
      assign pa.We   = we_a;
      assign pa.Be   = be_a;
      assign pa.Addr = addr_a;
      assign pa.Din  = din_a;
      assign pb.En   = en_b;
      assign pb.We   = we_b;
      assign pb.Be   = be_b;
      assign pb.Addr = addr_b;
      assign pb.Din  = din_b;

      assign dout_a_o[g] = pa.Dout;
      assign vld_a_o[g]  = pa.Vld;
      assign dout_b_o[g] = pb.Dout;
      assign vld_b_o[g]  = pb.Vld;

      tdp_ram_param #(
         .DW        (16),
         .AW        (8),
         .DEPTH     ((g == 2) ? 256 : 200),
         .OUT_REG   ((g == 0) ? 0 : 1),
         .COLL_MODE (g)
      ) dut (
         .Clk    (clk),
         .Clr    (clr),
         .Init   (init),
         .SPM    (spm),
         .Busy   (busy_o[g]),
         .port_a (pa),
         .port_b (pb),
         .Coll   (coll_o[g]),
         .OobErr (oob_o[g])
      );
   end

   // Reference model state
   logic [15:0] mem_m [NDUT][256];
   int          clr_left [NDUT];
   bit          coll_m [NDUT];
   bit          oob_m  [NDUT];
   logic [15:0] held   [NDUT][2];
   bit          sv     [NDUT][2][4];
   logic [15:0] sd     [NDUT][2][4];
   int          cyc;
   int          checks;
   int          errors;

   function automatic int dep_of(input int d);
      return (d == 2) ? 256 : 200;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic logic [15:0] wmerge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
      logic [15:0] mask;
      mask = {{8{be[1]}}, {8{be[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic post(input int d, input int p, input logic [15:0] data);
      int slot;
      slot = (cyc + lat_of(d) - 1) & 3;
      sv[d][p][slot] = 1'b1;
      sd[d][p][slot] = data;
   endtask

   task automatic model_clear(input int d);
      clr_left[d] = dep_of(d);
      coll_m[d]   = 1'b0;
      oob_m[d]    = 1'b0;
      for (int i = 0; i < 256; i++) mem_m[d][i] = 16'h0;
   endtask

   // Apply the rules for the edge about to happen, using the current inputs.
   task automatic model_edge();
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         if (clr) begin
            model_clear(d);
            for (int p = 0; p < 2; p++) begin
               held[d][p] = 16'h0;
               for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;
            end
         end else if (clr_left[d] > 0) begin
            clr_left[d]--;
         end else begin
            bit ra, rb, oa, ob, hit, wa, wb;
            ra  = en_a;
            rb  = en_b && !spm;
            oa  = int'(addr_a) >= dep_of(d);
            ob  = int'(addr_b) >= dep_of(d);
            if (ra && !we_a) post(d, 0, oa ? 16'h0 : mem_m[d][addr_a]);
            if (rb && !we_b) post(d, 1, ob ? 16'h0 : mem_m[d][addr_b]);
            hit = ra && we_a && rb && we_b && (addr_a == addr_b);
            wa  = ra && we_a && !oa && (!hit || d == 0);
            wb  = rb && we_b && !ob && (!hit || d == 1);
            if (wa) mem_m[d][addr_a] = wmerge(mem_m[d][addr_a], din_a, be_a);
            if (wb) mem_m[d][addr_b] = wmerge(mem_m[d][addr_b], din_b, be_b);
            if (hit) coll_m[d] = 1'b1;
            if ((ra && oa) || (rb && ob)) oob_m[d] = 1'b1;
            if (init) model_clear(d);
         end
      end
   endtask

   task automatic compare();
      for (int d = 0; d < NDUT; d++) begin
         int slot;
         slot = cyc & 3;
         check($sformatf("dut%0d.busy", d), 32'(busy_o[d]),
               32'((clr || clr_left[d] > 0) ? 1 : 0));
         for (int p = 0; p < 2; p++) begin
            bit ev;
            ev = sv[d][p][slot];
            if (ev) begin
               held[d][p]     = sd[d][p][slot];
               sv[d][p][slot] = 1'b0;
            end
            check($sformatf("dut%0d.vld%s", d, p == 0 ? "A" : "B"),
                  32'(p == 0 ? vld_a_o[d] : vld_b_o[d]), 32'(ev));
            check($sformatf("dut%0d.dout%s", d, p == 0 ? "A" : "B"),
                  32'(p == 0 ? dout_a_o[d] : dout_b_o[d]), 32'(held[d][p]));
         end
         check($sformatf("dut%0d.coll", d), 32'(coll_o[d]), 32'(coll_m[d]));
         check($sformatf("dut%0d.oob", d), 32'(oob_o[d]), 32'(oob_m[d]));
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      init = 1'b0;
      spm  = 1'b0;
      en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = 8'h00; din_a = 16'h0;
      en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = 8'h00; din_b = 16'h0;
   endtask

   task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                        input logic [7:0] addr, input logic [15:0] din);
      en_a = en; we_a = we; be_a = be; addr_a = addr; din_a = din;
   endtask

   task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                        input logic [7:0] addr, input logic [15:0] din);
      en_b = en; we_b = we; be_b = be; addr_b = addr; din_b = din;
   endtask

   function automatic logic [7:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) return 8'($urandom_range(0, 7));
      if (r < 8) return 8'($urandom_range(0, 255));
      return 8'($urandom_range(190, 255));
   endfunction

   task automatic rand_inputs();
      set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            pick_addr(), 16'($urandom));
      set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            pick_addr(), 16'($urandom));
      spm  = ($urandom_range(0, 7) == 0);
      init = ($urandom_range(0, 799) == 0);
   endtask

   task automatic read_sweep();
      for (int i = 0; i < 256; i++) begin
         set_a(1'b1, 1'b0, 2'b00, 8'(i), 16'h0);
         set_b(1'b1, 1'b0, 2'b00, 8'(255 - i), 16'h0);
         step();
      end
      idle();
      repeat (3) step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int d = 0; d < NDUT; d++) begin
         clr_left[d] = 0;
         coll_m[d]   = 1'b0;
         oob_m[d]    = 1'b0;
         for (int p = 0; p < 2; p++) begin
            held[d][p] = 16'h0;
            for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;
         end
      end
      idle();
      clr = 1'b0;
      #2 clr = 1'b1;

      // Reset state and full clear after Clr release
      repeat (3) step();
      clr = 1'b0;
      repeat (260) step();
      read_sweep();

      // Byte-enable writes then readback
      set_a(1'b1, 1'b1, 2'b11, 8'h10, 16'hABCD); step();
      set_a(1'b1, 1'b1, 2'b01, 8'h10, 16'h1234); step();
      idle(); set_b(1'b1, 1'b0, 2'b00, 8'h10, 16'h0); step();
      idle(); repeat (3) step();

      // Read-first across ports
      set_a(1'b1, 1'b1, 2'b11, 8'h03, 16'h005A); set_b(1'b1, 1'b0, 2'b00, 8'h03, 16'h0); step();
      idle(); set_b(1'b1, 1'b0, 2'b00, 8'h03, 16'h0); step();
      idle(); repeat (3) step();

      // Write-write collision on a preset word
      set_a(1'b1, 1'b1, 2'b11, 8'h07, 16'h0077); step();
      set_a(1'b1, 1'b1, 2'b11, 8'h07, 16'h0011); set_b(1'b1, 1'b1, 2'b11, 8'h07, 16'h0022); step();
      idle(); set_a(1'b1, 1'b0, 2'b00, 8'h07, 16'h0); step();
      idle(); repeat (3) step();

      // Single-port mode ignores port B
      spm = 1'b1; set_b(1'b1, 1'b1, 2'b11, 8'h05, 16'h0099); step();
      set_b(1'b1, 1'b0, 2'b00, 8'h05, 16'h0); step();
      idle(); set_a(1'b1, 1'b0, 2'b00, 8'h05, 16'h0); step();
      idle(); repeat (3) step();

      // Out-of-range accesses (DEPTH=200 instances)
      set_a(1'b1, 1'b0, 2'b00, 8'd250, 16'h0); step();
      idle(); set_b(1'b1, 1'b1, 2'b11, 8'd201, 16'hFFFF); step();
      idle(); set_b(1'b1, 1'b0, 2'b00, 8'd201, 16'h0); step();
      idle(); repeat (3) step();

      // Random traffic
      repeat (3000) begin rand_inputs(); step(); end

      // Init pulsed mid-traffic, traffic keeps coming during the clear
      rand_inputs(); init = 1'b1; step();
      repeat (300) begin rand_inputs(); init = 1'b0; step(); end
      idle(); read_sweep();

      // Clr part-way through a clear restarts it
      idle(); init = 1'b1; step();
      init = 1'b0; repeat (100) step();
      clr = 1'b1; repeat (2) step();
      clr = 1'b0; repeat (260) step();
      read_sweep();

      repeat (1000) begin rand_inputs(); step(); end
      idle(); repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
